// File: rtl/cpu_pkg.sv
// Purpose : shared types for the data-memory arbiter (owner encoding, default burst limit).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Which requester held the DM port in the previous cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  // Default cap on back-to-back debug grants while the CPU is also asking.
  localparam int BURST_MAX_DEF = 4;

endpackage

// File: rtl/dm_arbiter_if.sv
// Purpose : bundles the CPU, debug and shared data-memory signals of the arbiter.
// Latency : n/a (wiring only).
// Backpressure: cpu_stall holds the CPU; the debug side waits for dbg_ack.
// Ports   : slave = arbiter view, master = requesters + memory view.
interface dm_arbiter_if #(
  parameter int AW = 32
);
  // CPU side
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_stall;
  // Debug side
  logic          dbg_req;
  logic          dbg_we;
  logic          dbg_lock;
  logic [AW-1:0] dbg_addr;
  logic [31:0]   dbg_wdata;
  logic [31:0]   dbg_rdata;
  logic          dbg_ack;
  // Shared data-memory port
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_MemRead;
  logic          dm_MemWrite;
  logic [31:0]   dm_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output dm_addr, dm_wdata, dm_MemRead, dm_MemWrite,
    input  dm_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  dm_addr, dm_wdata, dm_MemRead, dm_MemWrite,
    output dm_rdata
  );
endinterface

// File: rtl/dm_arbiter_arb_pick.sv
// Purpose : combinational grant decision between CPU and debug for one DM port.
// Latency : 0 cycles (pure combinational).
// Backpressure: the loser of a contended cycle simply receives no grant.
// Ports   : cpu_req_i/dbg_req_i/dbg_lock_i requests, owner_i/bcnt_i registered state,
//           cpu_gnt_o/dbg_gnt_o one-hot-or-zero grants.
module arb_pick
  import cpu_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int BW        = $clog2(BURST_MAX + 1)
) (
  input  logic          cpu_req_i,
  input  logic          dbg_req_i,
  input  logic          dbg_lock_i,
  input  owner_e        owner_i,
  input  logic [BW-1:0] bcnt_i,
  output logic          cpu_gnt_o,
  output logic          dbg_gnt_o
);

  localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);

  always_comb begin
    cpu_gnt_o = 1'b0;
    dbg_gnt_o = 1'b0;
    if (cpu_req_i && dbg_req_i) begin
      unique case (owner_i)
        // A locked debug burst keeps the port until its budget is spent.
        OWN_DBG:  if (dbg_lock_i && (bcnt_i < BMAX)) dbg_gnt_o = 1'b1;
                  else                               cpu_gnt_o = 1'b1;
        OWN_CPU:  dbg_gnt_o = 1'b1;
        default:  cpu_gnt_o = 1'b1;
      endcase
    end else begin
      cpu_gnt_o = cpu_req_i;
      dbg_gnt_o = dbg_req_i;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Purpose : shares one data-memory port between the CPU and a debug master.
// Latency : grant and DM drive in the request cycle; dbg_ack/dbg_rdata one cycle after grant.
// Backpressure: CPU held via cpu_stall; debug request re-arbitrated every cycle until acked.
// Ports   : clk, rst (async, active-high), bus = dm_arbiter_if.slave.
module dm_arbiter
  import cpu_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int AW        = 32
) (
  input  logic         clk,
  input  logic         rst,
  dm_arbiter_if.slave  bus
);

  localparam int              BW   = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0]   BMAX = BW'(BURST_MAX);

  owner_e        owner_q, owner_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          dbg_ack_q;
  logic [31:0]   dbg_rdata_q;

  // Requests are masked during reset so the DM port and stall stay quiet.
  logic cpu_req_v, dbg_req_v;
  logic cpu_gnt, dbg_gnt;

  assign cpu_req_v = bus.cpu_req & ~rst;
  assign dbg_req_v = bus.dbg_req & ~rst;

  arb_pick #(
    .BURST_MAX (BURST_MAX),
    .BW        (BW)
  ) u_pick (
    .cpu_req_i  (cpu_req_v),
    .dbg_req_i  (dbg_req_v),
    .dbg_lock_i (bus.dbg_lock),
    .owner_i    (owner_q),
    .bcnt_i     (bcnt_q),
    .cpu_gnt_o  (cpu_gnt),
    .dbg_gnt_o  (dbg_gnt)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= OWN_NONE;
      bcnt_q      <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      owner_q   <= owner_d;
      bcnt_q    <= bcnt_d;
      dbg_ack_q <= dbg_gnt;
      if (dbg_gnt && !bus.dbg_we) dbg_rdata_q <= bus.dm_rdata;
    end
  end

  // Next-state: the burst counter only advances while the CPU is being held off.
  always_comb begin
    owner_d = OWN_NONE;
    bcnt_d  = '0;
    if (cpu_gnt) begin
      owner_d = OWN_CPU;
    end else if (dbg_gnt) begin
      owner_d = OWN_DBG;
      if (cpu_req_v) bcnt_d = (bcnt_q == BMAX) ? bcnt_q : bcnt_q + BW'(1);
    end
  end

  // Outputs: DM port follows the granted requester, otherwise all zero.
  always_comb begin
    bus.dm_addr     = {AW{1'b0}};
    bus.dm_wdata    = '0;
    bus.dm_MemRead  = 1'b0;
    bus.dm_MemWrite = 1'b0;
    bus.cpu_rdata   = '0;
    if (cpu_gnt) begin
      bus.dm_addr     = bus.cpu_addr;
      bus.dm_wdata    = bus.cpu_wdata;
      bus.dm_MemRead  = ~bus.cpu_we;
      bus.dm_MemWrite = bus.cpu_we;
      bus.cpu_rdata   = bus.dm_rdata;
    end else if (dbg_gnt) begin
      bus.dm_addr     = bus.dbg_addr;
      bus.dm_wdata    = bus.dbg_wdata;
      bus.dm_MemRead  = ~bus.dbg_we;
      bus.dm_MemWrite = bus.dbg_we;
    end
    bus.cpu_stall = cpu_req_v & ~cpu_gnt;
    bus.dbg_ack   = dbg_ack_q;
    bus.dbg_rdata = dbg_rdata_q;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Purpose : directed self-checking bench for dm_arbiter with a small word memory model.
// Latency : inputs driven 1ns after rising edge, outputs sampled on falling edge.
// Backpressure: n/a.
module tb_dm_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic preload;
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  int   wr0;

  logic [31:0] mem [0:63];
  logic        dpat [0:9];

  dm_arbiter_if #(.AW(32)) bus ();

  dm_arbiter #(.BURST_MAX(4), .AW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Word memory behind the DM port: combinational read, write on the rising edge.
  assign bus.dm_rdata = mem[bus.dm_addr[7:2]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'hDEADBEEF;  // 0x10
      mem[12] <= 32'hCAFEF00D;  // 0x30
      mem[16] <= 32'h0BADF00D;  // 0x40
    end else if (bus.dm_MemWrite) begin
      mem[bus.dm_addr[7:2]] <= bus.dm_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
  endtask

  task automatic dbg(input logic req, input logic we, input logic lock,
                     input logic [31:0] addr, input logic [31:0] wd);
    bus.dbg_req = req; bus.dbg_we = we; bus.dbg_lock = lock; bus.dbg_addr = addr; bus.dbg_wdata = wd;
  endtask

  initial begin
    // ---------------- reset, with both requesters active ----------------
    rst = 1'b1;
    preload = 1'b1;
    cpu(1'b1, 1'b0, 32'h10, 32'h0);
    dbg(1'b1, 1'b1, 1'b0, 32'h40, 32'h55555555);
    tick();
    @(negedge clk);
    chk("rst_stall",    {31'b0, bus.cpu_stall},   32'h0);
    chk("rst_cpu_rd",   bus.cpu_rdata,            32'h0);
    chk("rst_memrd",    {31'b0, bus.dm_MemRead},  32'h0);
    chk("rst_memwr",    {31'b0, bus.dm_MemWrite}, 32'h0);
    chk("rst_dm_addr",  bus.dm_addr,              32'h0);
    chk("rst_ack",      {31'b0, bus.dbg_ack},     32'h0);
    chk("rst_dbg_rd",   bus.dbg_rdata,            32'h0);
    tick();
    rst = 1'b0;
    preload = 1'b0;

    // ---------------- CPU-only read ----------------
    cpu(1'b1, 1'b0, 32'h10, 32'h0);
    dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("cpu_only_stall", {31'b0, bus.cpu_stall},  32'h0);
    chk("cpu_only_rdata", bus.cpu_rdata,           32'hDEADBEEF);
    chk("cpu_only_memrd", {31'b0, bus.dm_MemRead}, 32'h1);
    tick();

    // ---------------- contended, no lock: CPU, DBG, CPU ----------------
    cpu(1'b0, 1'b0, 32'h0, 32'h0);   // idle cycle -> owner NONE
    @(negedge clk);
    chk("idle_addr", bus.dm_addr, 32'h0);
    tick();
    cpu(1'b1, 1'b0, 32'h10, 32'h0);
    dbg(1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
    @(negedge clk);
    chk("c0_stall", {31'b0, bus.cpu_stall}, 32'h0);
    chk("c0_addr",  bus.dm_addr,            32'h10);
    tick();
    chk("c0_ack", {31'b0, bus.dbg_ack}, 32'h0);
    @(negedge clk);
    chk("c1_stall", {31'b0, bus.cpu_stall}, 32'h1);
    chk("c1_cpu_rd", bus.cpu_rdata,         32'h0);
    chk("c1_addr",  bus.dm_addr,            32'h30);
    tick();
    chk("c1_ack",   {31'b0, bus.dbg_ack}, 32'h1);
    chk("c1_dbg_rd", bus.dbg_rdata,       32'hCAFEF00D);
    dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("c2_stall", {31'b0, bus.cpu_stall}, 32'h0);
    chk("c2_addr",  bus.dm_addr,            32'h10);
    tick();
    chk("c2_ack", {31'b0, bus.dbg_ack}, 32'h0);

    // ---------------- locked burst after a CPU grant: DBGx4, CPUx1 ----------------
    dpat[0] = 1; dpat[1] = 1; dpat[2] = 1; dpat[3] = 1; dpat[4] = 0;
    dpat[5] = 1; dpat[6] = 1; dpat[7] = 1; dpat[8] = 1; dpat[9] = 0;
    dbg(1'b1, 1'b0, 1'b1, 32'h30, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("burst_stall_%0d", k), {31'b0, bus.cpu_stall}, {31'b0, dpat[k]});
      chk($sformatf("burst_ack_%0d", k), {31'b0, bus.dbg_ack}, (k == 0) ? 32'h0 : {31'b0, dpat[k-1]});
      tick();
    end
    dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // ---------------- contended debug write ----------------
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    tick();                           // owner NONE
    wr0 = wr_cnt;
    cpu(1'b1, 1'b0, 32'h10, 32'h0);
    dbg(1'b1, 1'b1, 1'b0, 32'h20, 32'h12345678);
    @(negedge clk);
    chk("wr_a_stall", {31'b0, bus.cpu_stall},   32'h0);
    chk("wr_a_memwr", {31'b0, bus.dm_MemWrite}, 32'h0);
    tick();
    chk("wr_a_mem", mem[8], 32'h0);
    @(negedge clk);
    chk("wr_b_memwr", {31'b0, bus.dm_MemWrite}, 32'h1);
    chk("wr_b_stall", {31'b0, bus.cpu_stall},   32'h1);
    tick();
    chk("wr_b_ack", {31'b0, bus.dbg_ack}, 32'h1);
    chk("wr_b_mem", mem[8], 32'h12345678);
    dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cpu(1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    chk("wr_c_rdata", bus.cpu_rdata, 32'h12345678);
    tick();
    chk("wr_count", wr_cnt - wr0, 32'h1);

    // ---------------- debug request withdrawn before grant ----------------
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    tick();                           // owner NONE
    cpu(1'b1, 1'b0, 32'h10, 32'h0);
    dbg(1'b1, 1'b1, 1'b0, 32'h40, 32'hFFFF0000);
    @(negedge clk);
    chk("wd_stall", {31'b0, bus.dm_MemWrite}, 32'h0);
    tick();
    dbg(1'b0, 1'b1, 1'b0, 32'h40, 32'hFFFF0000);
    @(negedge clk);
    chk("wd_memwr", {31'b0, bus.dm_MemWrite}, 32'h0);
    chk("wd_ack0",  {31'b0, bus.dbg_ack},     32'h0);
    tick();
    chk("wd_ack1", {31'b0, bus.dbg_ack}, 32'h0);
    chk("wd_mem",  mem[16], 32'h0BADF00D);

    // ---------------- reset with a pending second debug request ----------------
    dbg(1'b1, 1'b0, 1'b0, 32'h30, 32'h0);   // owner CPU -> DBG granted
    @(negedge clk);
    chk("rs_grant", {31'b0, bus.cpu_stall}, 32'h1);
    tick();
    chk("rs_ack_pre", {31'b0, bus.dbg_ack}, 32'h1);
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    dbg(1'b1, 1'b1, 1'b1, 32'h40, 32'h11111111);
    rst = 1'b1;
    #1;
    chk("rs_ack_now", {31'b0, bus.dbg_ack},     32'h0);
    chk("rs_memwr",   {31'b0, bus.dm_MemWrite}, 32'h0);
    chk("rs_dbg_rd",  bus.dbg_rdata,            32'h0);
    tick();
    chk("rs_mem", mem[16], 32'h0BADF00D);
    rst = 1'b0;
    cpu(1'b1, 1'b0, 32'h10, 32'h0);         // locked DBG would win only if owner were DBG
    @(negedge clk);
    chk("rs_owner_none", {31'b0, bus.cpu_stall}, 32'h0);
    chk("rs_ack_after",  {31'b0, bus.dbg_ack},   32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
